spi_frame_rx: RTL and testbench

Upstream SPI front end for the onboarding peripheral. It sits between the raw SCLK/COPI/nCS pins and the register bank that drives the PWM peripheral. It synchronises the pins into the system clock domain, deserialises 16-bit frames and emits one-cycle register-write strobes. Malformed, read and out-of-range frames are flagged and never produce a write.

---
 rtl/spi_frame_rx_if.sv | 24 ++
 rtl/spi_frame_rx.sv | 150 +++++++++++++++
 tb/tb_spi_frame_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_rx_if.sv
// Pin-side SPI signals and register-write strobes of the SPI frame receiver.
// The slave modport is the receiver's view. The master modport is the
// view of whatever drives the pins and consumes the strobes.
interface spi_frame_rx_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       addr_err;
    logic       busy;

    modport slave (
        input  sclk, copi, ncs,
        output wr_valid, wr_addr, wr_data, frame_err, addr_err, busy
    );

    modport master (
        output sclk, copi, ncs,
        input  wr_valid, wr_addr, wr_data, frame_err, addr_err, busy
    );
endinterface

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver.
// The SCLK, COPI and nCS pins are synchronised into the clk domain. Each
// frame is 1 R/W bit + 7 address bits + 8 data bits. A valid write produces
// a one-cycle register-write strobe. Short, long and out-of-range frames
// produce an error pulse instead. Read frames are dropped silently.
module spi_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5,
    parameter int FRAME_BITS  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_frame_rx_if.slave    bus
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);
    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, RECV, OVER} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_prev_q, ncs_prev_q;
    logic                   s_sclk, s_copi, s_ncs;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    wr_valid_q, wr_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    addr_err_q, addr_err_d;
    logic [6:0]              wr_addr_q, wr_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic                    busy_q;

    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_write;

    assign s_sclk = sclk_sync_q[SYNC_STAGES-1];
    assign s_copi = copi_sync_q[SYNC_STAGES-1];
    assign s_ncs  = ncs_sync_q[SYNC_STAGES-1];

    assign sclk_rise = s_sclk & ~sclk_prev_q;
    assign ncs_fall  = ~s_ncs & ncs_prev_q;
    assign ncs_rise  = s_ncs & ~ncs_prev_q;

    assign frame_write = shift_q[FRAME_BITS-1];
    assign frame_addr  = shift_q[FRAME_BITS-2 -: 7];
    assign frame_data  = shift_q[7:0];

    // Pin synchronisers plus one history flop each; reset presets an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], bus.copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
            sclk_prev_q <= s_sclk;
            ncs_prev_q  <= s_ncs;
        end
    end

    // State, shift register, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            addr_err_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            addr_err_q  <= addr_err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= ~s_ncs;
        end
    end

    // Next-state and frame evaluation. nCS rising takes priority over a
    // coincident SCLK edge, so that edge is never shifted in.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        addr_err_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = RECV;
                end
            end
            RECV, OVER: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (state_q == OVER) begin
                        frame_err_d = 1'b1;
                    end else if (cnt_q == '0) begin
                        frame_err_d = 1'b0;
                    end else if (cnt_q != FULL_CNT) begin
                        frame_err_d = 1'b1;
                    end else if (frame_write) begin
                        if ({1'b0, frame_addr} >= NUM_REGS_W) begin
                            addr_err_d = 1'b1;
                        end else begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = frame_addr;
                            wr_data_d  = frame_data;
                        end
                    end
                end else if (state_q == RECV && sclk_rise) begin
                    if (cnt_q == FULL_CNT) begin
                        state_d = OVER;
                    end else begin
                        shift_d = {shift_q[FRAME_BITS-2:0], s_copi};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: a table of whole frames followed by
// hand-written sequences for the multi-cycle corner cases.
module tb_spi_frame_rx;
    logic clk = 1'b0;
    logic rst_n;

    spi_frame_rx_if bus();

    spi_frame_rx #(.SYNC_STAGES(2), .NUM_REGS(5), .FRAME_BITS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse and protocol monitor, sampled 1 ns after each rising edge.
    int wr_cnt = 0, fe_cnt = 0, ae_cnt = 0, overlap = 0, hold_viol = 0;
    logic [6:0] pa = '0;
    logic [7:0] pd = '0;
    logic       prev_rst = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus.wr_valid)  wr_cnt++;
        if (bus.frame_err) fe_cnt++;
        if (bus.addr_err)  ae_cnt++;
        if (32'(bus.wr_valid) + 32'(bus.frame_err) + 32'(bus.addr_err) > 1) overlap++;
        if (rst_n && prev_rst && !bus.wr_valid && (bus.wr_addr != pa || bus.wr_data != pd))
            hold_viol++;
        pa = bus.wr_addr;
        pd = bus.wr_data;
        prev_rst = rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 frame, MSB first, SCLK period 8 clk; n=0 gives an empty select.
    task automatic send_bits(input logic [31:0] v, input int n);
        bus.ncs = 1'b0;
        clk_n(6);
        for (int i = n - 1; i >= 0; i--) begin
            bus.copi = v[i];
            clk_n(4);
            bus.sclk = 1'b1;
            clk_n(4);
            bus.sclk = 1'b0;
        end
        clk_n(4);
        bus.ncs = 1'b1;
        clk_n(12);
    endtask

    typedef struct {
        string       name;
        logic [31:0] frame;
        int          nbits;
        int          exp_wr;
        int          exp_fe;
        int          exp_ae;
        logic [6:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, f0, a0;

        vecs[0] = '{"wr_8155",   32'h8155,  16, 1, 0, 0, 7'd1, 8'h55};
        vecs[1] = '{"wr_80F0",   32'h80F0,  16, 1, 0, 0, 7'd0, 8'hF0};
        vecs[2] = '{"wr_84AA",   32'h84AA,  16, 1, 0, 0, 7'd4, 8'hAA};
        vecs[3] = '{"rd_0133",   32'h0133,  16, 0, 0, 0, 7'd4, 8'hAA};
        vecs[4] = '{"addr_8712", 32'h8712,  16, 0, 0, 1, 7'd4, 8'hAA};
        vecs[5] = '{"short_10",  32'h3FF,   10, 0, 1, 0, 7'd4, 8'hAA};
        vecs[6] = '{"long_20",   32'hFFFFF, 20, 0, 1, 0, 7'd4, 8'hAA};
        vecs[7] = '{"empty_0",   32'h0,      0, 0, 0, 0, 7'd4, 8'hAA};

        // Reset state
        rst_n    = 1'b0;
        bus.sclk = 1'b0;
        bus.copi = 1'b0;
        bus.ncs  = 1'b1;
        clk_n(3);
        chk("reset_flags", {29'd0, bus.wr_valid, bus.frame_err, bus.addr_err}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_bus", {17'd0, bus.wr_addr, bus.wr_data}, 32'd0);
        rst_n = 1'b1;
        clk_n(5);

        // Table of whole frames
        for (int k = 0; k < 8; k++) begin
            w0 = wr_cnt; f0 = fe_cnt; a0 = ae_cnt;
            send_bits(vecs[k].frame, vecs[k].nbits);
            chk({vecs[k].name, "_wr"},   32'(wr_cnt - w0), 32'(vecs[k].exp_wr));
            chk({vecs[k].name, "_ferr"}, 32'(fe_cnt - f0), 32'(vecs[k].exp_fe));
            chk({vecs[k].name, "_aerr"}, 32'(ae_cnt - a0), 32'(vecs[k].exp_ae));
            chk({vecs[k].name, "_addr"}, 32'(bus.wr_addr), 32'(vecs[k].exp_addr));
            chk({vecs[k].name, "_data"}, 32'(bus.wr_data), 32'(vecs[k].exp_data));
        end

        // SCLK toggling while deselected
        w0 = wr_cnt; f0 = fe_cnt; a0 = ae_cnt;
        repeat (5) begin
            bus.copi = 1'b1;
            bus.sclk = 1'b1;
            clk_n(4);
            bus.sclk = 1'b0;
            clk_n(4);
        end
        clk_n(10);
        chk("desel_pulses", 32'((wr_cnt - w0) + (fe_cnt - f0) + (ae_cnt - a0)), 32'd0);
        chk("desel_busy", {31'd0, bus.busy}, 32'd0);

        // 16th SCLK rise coincides with nCS rise: only 15 bits count
        w0 = wr_cnt; f0 = fe_cnt; a0 = ae_cnt;
        bus.ncs = 1'b0;
        clk_n(6);
        for (int i = 15; i >= 1; i--) begin
            bus.copi = 1'(32'h8155 >> i);
            clk_n(4);
            bus.sclk = 1'b1;
            clk_n(4);
            bus.sclk = 1'b0;
        end
        bus.copi = 1'b1;
        clk_n(4);
        bus.sclk = 1'b1;
        bus.ncs  = 1'b1;
        clk_n(4);
        bus.sclk = 1'b0;
        clk_n(12);
        chk("coinc_ferr", 32'(fe_cnt - f0), 32'd1);
        chk("coinc_wr", 32'(wr_cnt - w0), 32'd0);
        chk("coinc_aerr", 32'(ae_cnt - a0), 32'd0);

        // Reset in the middle of a frame
        bus.ncs = 1'b0;
        clk_n(6);
        for (int i = 15; i >= 8; i--) begin
            bus.copi = 1'(32'h8255 >> i);
            clk_n(4);
            bus.sclk = 1'b1;
            clk_n(4);
            bus.sclk = 1'b0;
        end
        chk("midframe_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {29'd0, bus.wr_valid, bus.frame_err, bus.addr_err}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_bus", {17'd0, bus.wr_addr, bus.wr_data}, 32'd0);
        bus.ncs = 1'b1;
        w0 = wr_cnt; f0 = fe_cnt; a0 = ae_cnt;
        clk_n(3);
        rst_n = 1'b1;
        clk_n(12);
        chk("postrst_pulses", 32'((wr_cnt - w0) + (fe_cnt - f0) + (ae_cnt - a0)), 32'd0);
        send_bits(32'h8209, 16);
        chk("postrst_wr", 32'(wr_cnt - w0), 32'd1);
        chk("postrst_addr", 32'(bus.wr_addr), 32'd2);
        chk("postrst_data", 32'(bus.wr_data), 32'h09);
        chk("postrst_err", 32'((fe_cnt - f0) + (ae_cnt - a0)), 32'd0);

        // Whole-run protocol properties
        chk("one_hot_pulses", 32'(overlap), 32'd0);
        chk("addr_data_hold", 32'(hold_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
